bram_read_arbiter: RTL

BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

---
 rtl/bram_read_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/bram_read_arbiter.sv
// rtl/bram_read_arbiter.sv - two-port read arbiter in front of a single-read-port block RAM
// Grants are combinational; the response tag follows the memory's one-cycle read latency.
module bram_read_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int FIXED_PRIORITY = 0,
  parameter int MAX_WAIT       = 15
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rd0_req,
  input  logic [ADDR_WIDTH-1:0] rd0_addr,
  input  logic                  rd1_req,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd0_gnt,
  output logic                  rd1_gnt,
  output logic                  rd0_valid,
  output logic                  rd1_valid,
  output logic [DATA_WIDTH-1:0] rd0_data,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic [ADDR_WIDTH-1:0] bram_read_addr,
  output logic                  bram_read_enable,
  input  logic [DATA_WIDTH-1:0] bram_read_data
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic       last_gnt;
  logic [7:0] wait_cnt;
  logic       resp_valid;
  logic       resp_port;
  logic       conflict_pick1;

  always_comb begin
    conflict_pick1 = (FIXED_PRIORITY != 0) ? (wait_cnt == MAX_WAIT_C) : ~last_gnt;
    rd0_gnt = 1'b0;
    rd1_gnt = 1'b0;
    if (resetn) begin
      if (rd0_req && rd1_req) begin
        rd0_gnt = ~conflict_pick1;
        rd1_gnt = conflict_pick1;
      end else begin
        rd0_gnt = rd0_req;
        rd1_gnt = rd1_req;
      end
    end
    bram_read_addr = rd1_gnt ? rd1_addr : rd0_addr;
  end

  assign bram_read_enable = rd0_gnt | rd1_gnt;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_valid <= 1'b0;
      resp_port  <= 1'b0;
      wait_cnt   <= 8'd0;
      last_gnt   <= 1'b1;
    end else begin
      resp_valid <= bram_read_enable;
      resp_port  <= rd1_gnt;
      if (bram_read_enable) last_gnt <= rd1_gnt;
      // Starvation counter saturates so the forced grant stays pending until taken.
      if (rd1_req && !rd1_gnt) begin
        if (wait_cnt < MAX_WAIT_C) wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  assign rd0_valid = resp_valid & ~resp_port;
  assign rd1_valid = resp_valid & resp_port;
  assign rd0_data  = bram_read_data;
  assign rd1_data  = bram_read_data;

endmodule
